// File: rtl/rng_word_arbiter.sv
// rng_word_arbiter: two requesters share one 16-bit LFSR. A granted requester
// receives a WORD_W-bit word assembled one LFSR bit per cycle, then a one-cycle ack.
module rng_word_arbiter #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  output logic [1:0]        ack,
  output logic [WORD_W-1:0] data,
  output logic              busy
);

  localparam int unsigned LFSR_W = 16;
  // Counter only needs to reach WORD_W-1.
  localparam int unsigned CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WORD_W - 1);
  localparam logic [LFSR_W-1:0] LFSR_RESET = LFSR_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e              state_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [LFSR_W-1:0]   lfsr_d;
  logic [WORD_W-1:0]   shift_q;
  logic [WORD_W-1:0]   shift_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                grant_q;
  logic                last_q;
  logic                grant_c;
  logic [LFSR_W-1:0]   seed_c;
  logic [1:0]          ack_q;
  logic [WORD_W-1:0]   data_q;
  logic                busy_q;

  // LFSR advance; the map is invertible so a nonzero state never reaches zero.
  assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Shift in the current random bit; truncation also covers WORD_W == 1.
  assign shift_d = WORD_W'({shift_q, lfsr_q[0]});

  // Round-robin: single request wins outright, contention goes to the other side.
  assign grant_c = (req == 2'b11) ? ~last_q : req[1];

  // A zero seed would lock the LFSR, so substitute 1.
  assign seed_c  = (seed == '0) ? LFSR_RESET : seed;

  // Arbiter / collector FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_RESET;
      shift_q <= '0;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ack_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seed_load) begin
            lfsr_q <= seed_c;
          end else if (req != 2'b00) begin
            grant_q <= grant_c;
            last_q  <= grant_c;
            cnt_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b1;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          shift_q <= shift_d;
          lfsr_q  <= lfsr_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (!req[grant_q]) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            ack_q   <= grant_q ? 2'b10 : 2'b01;
            data_q  <= shift_d;
            busy_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack  = ack_q;
  assign data = data_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rng_word_arbiter.sv
// Testbench for rng_word_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_rng_word_arbiter;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic          seed_load;
  logic [15:0]   seed;
  logic [1:0]    ack;
  logic [W-1:0]  data;
  logic          busy;

  rng_word_arbiter #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .seed_load (seed_load),
    .seed      (seed),
    .ack       (ack),
    .data      (data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 word ready.
  int          m_phase;
  logic [15:0] m_lfsr;
  int          m_last;
  int          m_grant;
  int          m_bits;
  int          m_word;

  // Observed ack history for directed checks.
  int          n_acks = 0;
  logic [1:0]  last_ack;
  int          last_data;
  int          last_ack_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    logic fb;
    fb = r[15] ^ r[13] ^ r[12] ^ r[10];
    return (r << 1) | 16'(fb);
  endfunction

  // Apply one clock of the rules to the model using the current inputs.
  task automatic model_step();
    int bitv;
    if (!rst_n) begin
      m_phase = 0; m_lfsr = 16'h0001; m_last = 1; m_bits = 0; m_word = 0;
    end else if (m_phase == 0) begin
      if (seed_load) begin
        m_lfsr = (seed == 16'h0) ? 16'h0001 : seed;
      end else if (req != 2'b00) begin
        if (req == 2'b11) m_grant = 1 - m_last;
        else              m_grant = (req == 2'b10) ? 1 : 0;
        m_last  = m_grant;
        m_bits  = 0;
        m_word  = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      bitv   = int'(m_lfsr[0]);
      m_lfsr = lfsr_next(m_lfsr);
      m_word = (m_word * 2 + bitv) % (1 << W);
      m_bits++;
      if (req[m_grant] == 1'b0) m_phase = 0;
      else if (m_bits == W)     m_phase = 2;
    end else begin
      m_phase = 0;
    end
  endtask

  // One clock: advance model, clock DUT, compare outputs after the edge.
  task automatic tick();
    logic [1:0] e_ack;
    int         e_data;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    e_ack  = (m_phase == 2) ? ((m_grant == 1) ? 2'b10 : 2'b01) : 2'b00;
    e_data = (m_phase == 2) ? m_word : 0;
    check_eq("ack",  32'(ack),  32'(e_ack));
    check_eq("data", 32'(data), 32'(e_data));
    check_eq("busy", 32'(busy), 32'(m_phase != 0));
    if (ack != 2'b00) begin
      n_acks++;
      last_ack     = ack;
      last_data    = int'(data);
      last_ack_cyc = cyc;
    end
  endtask

  // Clock until a new ack appears or the budget runs out.
  task automatic wait_ack(input int budget);
    int start;
    start = n_acks;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_acks != start) return;
    end
    check_eq("ack_timeout", 32'(n_acks - start), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int t0;
  int prev_cyc;

  initial begin
    rst_n = 1'b0; req = 2'b00; seed_load = 1'b0; seed = 16'h0;
    m_phase = 0; m_lfsr = 16'h0001; m_last = 1; m_grant = 0; m_bits = 0; m_word = 0;
    last_ack = 2'b00; last_data = 0; last_ack_cyc = 0;
    do_reset();
    check_eq("rst_ack",  32'(ack),  32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // First word after reset, then a back-to-back second word.
    req = 2'b01;
    t0 = cyc;
    tick();
    check_eq("busy_t1", 32'(busy), 32'd1);
    wait_ack(20);
    check_eq("lat_first", 32'(last_ack_cyc - t0), 32'(W + 1));
    check_eq("word1", 32'(last_data), 32'h80);
    check_eq("ack1", 32'(last_ack), 32'h1);
    prev_cyc = last_ack_cyc;
    wait_ack(20);
    check_eq("word2", 32'(last_data), 32'h16);
    check_eq("spacing", 32'(last_ack_cyc - prev_cyc), 32'(W + 2));
    req = 2'b00;
    tick();

    // Contention alternates starting with requester 0.
    do_reset();
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      prev_cyc = last_ack_cyc;
      wait_ack(20);
      check_eq("rr_ack", 32'(last_ack), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) check_eq("rr_spacing", 32'(last_ack_cyc - prev_cyc), 32'(W + 2));
    end
    req = 2'b00;
    tick();
    tick();

    // Zero seed loads 1; seed_load outranks the simultaneous request.
    seed_load = 1'b1; seed = 16'h0; req = 2'b01;
    t0 = cyc;
    tick();
    check_eq("seed_busy", 32'(busy), 32'd0);
    seed_load = 1'b0;
    wait_ack(20);
    check_eq("seed_lat", 32'(last_ack_cyc - t0), 32'(W + 2));
    check_eq("seed_word", 32'(last_data), 32'h80);
    req = 2'b00;
    tick();

    // Abort on the 4th collect cycle; next word continues the bit stream.
    seed_load = 1'b1; seed = 16'h0001;
    tick();
    seed_load = 1'b0; req = 2'b01;
    tick();
    for (int k = 0; k < 3; k++) tick();
    req = 2'b00;
    prev_cyc = n_acks;
    tick();
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_noack", 32'(n_acks - prev_cyc), 32'd0);
    req = 2'b01;
    wait_ack(20);
    check_eq("abort_word", 32'(last_data), 32'h01);
    req = 2'b00;
    tick();

    // Reset during the last collect cycle kills the pending ack.
    req = 2'b01;
    tick();
    for (int k = 0; k < W - 1; k++) tick();
    rst_n = 1'b0;
    prev_cyc = n_acks;
    tick();
    rst_n = 1'b1;
    check_eq("rstdone_noack", 32'(n_acks - prev_cyc), 32'd0);
    check_eq("rstdone_busy", 32'(busy), 32'd0);
    check_eq("rstdone_data", 32'(data), 32'd0);
    wait_ack(20);
    check_eq("rstdone_word", 32'(last_data), 32'h80);
    req = 2'b00;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req[0] = ~req[0];
      if ($urandom_range(7) == 0) req[1] = ~req[1];
      seed_load = ($urandom_range(31) == 0);
      seed      = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
      rst_n     = ($urandom_range(199) != 0);
      tick();
    end
    rst_n = 1'b1; seed_load = 1'b0; req = 2'b00;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
